// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA datapath: digit width, Montgomery FSM states
// and the digit-count helper.
package rsa_pkg;

  localparam int WORD = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MCALC = 2'd1,
    ACC   = 2'd2,
    SUB   = 2'd3
  } state_t;

  function automatic int num_words(input int nbits);
    return nbits / WORD;
  endfunction

endpackage

// File: rtl/mont_mac_row.sv
// One Montgomery row: (acc + m*n) >> WORD, purely combinational so the wide
// 64 x NBITS multiplier can later be pipelined without touching the FSM.
module mont_mac_row
  import rsa_pkg::*;
#(
  parameter int NBITS = 512
) (
  input  logic [2*NBITS:0]      acc,
  input  logic [WORD-1:0]       m,
  input  logic [NBITS-1:0]      n,
  output logic [2*NBITS-WORD:0] sum
);

  logic [NBITS+WORD-1:0] mn_s;
  logic [2*NBITS:0]      full_s;

  assign mn_s   = {{NBITS{1'b0}}, m} * {{WORD{1'b0}}, n};
  // m was chosen so the low digit of this sum is zero; dropping it is exact
  assign full_s = acc + {{(NBITS + 1 - WORD){1'b0}}, mn_s};
  assign sum    = (2*NBITS-WORD+1)'(full_s >> WORD);

endmodule

// File: rtl/mont_redc.sv
// Word-serial Montgomery reduction: result = t * 2^-NBITS mod n, one MCALC/ACC
// pair per 64-bit digit followed by a single conditional subtract.
module mont_redc
  import rsa_pkg::*;
#(
  parameter int NBITS = 512
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2*NBITS-1:0]   t,
  input  logic [NBITS-1:0]     n,
  input  logic [WORD-1:0]      n0prime,
  output logic [NBITS-1:0]     result,
  output logic                 busy,
  output logic                 done
);

  localparam int S  = num_words(NBITS);
  localparam int CW = $clog2(S) + 1;

  state_t                 state_r;
  logic [2*NBITS:0]       acc_r;
  logic [WORD-1:0]        m_r;
  logic [WORD-1:0]        n0cap_r;
  logic [NBITS-1:0]       ncap_r;
  logic [NBITS-1:0]       result_r;
  logic [CW-1:0]          i_r;
  logic                   busy_r;
  logic                   done_r;
  logic [2*NBITS-WORD:0]  row_s;

  mont_mac_row #(.NBITS(NBITS)) u_row (
    .acc (acc_r),
    .m   (m_r),
    .n   (ncap_r),
    .sum (row_s)
  );

  // Control FSM, digit counter, accumulator and final conditional subtract.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      acc_r    <= '0;
      m_r      <= '0;
      n0cap_r  <= '0;
      ncap_r   <= '0;
      result_r <= '0;
      i_r      <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            acc_r   <= {1'b0, t};
            ncap_r  <= n;
            n0cap_r <= n0prime;
            i_r     <= '0;
            busy_r  <= 1'b1;
            state_r <= MCALC;
          end
        end
        MCALC: begin
          m_r     <= acc_r[WORD-1:0] * n0cap_r;
          state_r <= ACC;
        end
        ACC: begin
          acc_r <= {{WORD{1'b0}}, row_s};
          i_r   <= i_r + CW'(1);
          if (i_r == CW'(S - 1)) begin
            state_r <= SUB;
          end else begin
            state_r <= MCALC;
          end
        end
        SUB: begin
          // the pre-subtract value is below 2n, so one subtract fully reduces it
          if (acc_r >= {{(NBITS + 1){1'b0}}, ncap_r}) begin
            result_r <= NBITS'(acc_r - {{(NBITS + 1){1'b0}}, ncap_r});
          end else begin
            result_r <= acc_r[NBITS-1:0];
          end
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign result = result_r;
  assign busy   = busy_r;
  assign done   = done_r;

endmodule

// File: tb/tb_mont_redc.sv
// Self-checking bench for mont_redc: directed cases plus randomized runs against
// a bit-serial halving model of t * 2^-NBITS mod n.
module tb_mont_redc;

  localparam int NB  = 512;
  localparam int LAT = 18;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [2*NB-1:0] t;
  logic [NB-1:0]   n;
  logic [63:0]     n0prime;
  logic [NB-1:0]   result;
  logic            busy;
  logic            done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [NB-1:0] exp_q[$];
  int            st_q[$];

  mont_redc #(.NBITS(NB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .t       (t),
    .n       (n),
    .n0prime (n0prime),
    .result  (result),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // t * 2^-NB mod n by NB modular halvings of (t mod n)
  function automatic logic [NB-1:0] model(input logic [2*NB-1:0] tv, input logic [NB-1:0] nv);
    logic [2*NB-1:0] nn;
    logic [2*NB-1:0] x;
    nn = {{NB{1'b0}}, nv};
    x  = tv % nn;
    for (int k = 0; k < NB; k++) begin
      if (x[0]) x = (x + nn) >> 1;
      else      x = x >> 1;
    end
    return x[NB-1:0];
  endfunction

  function automatic logic [63:0] calc_n0(input logic [63:0] nlo);
    logic [63:0] x;
    x = nlo;
    for (int k = 0; k < 6; k++) x = x * (64'd2 - nlo * x);
    return -x;
  endfunction

  function automatic logic [NB-1:0] rand512();
    logic [NB-1:0] r;
    for (int k = 0; k < NB / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // compare process: every done pulse must match the oldest accepted request
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", {{(NB-1){1'b0}}, done}, {NB{1'b0}});
      end else begin
        logic [NB-1:0] e;
        int c0;
        e  = exp_q.pop_front();
        c0 = st_q.pop_front();
        check("result", result, e);
        check("latency", NB'(cyc - c0), NB'(LAT));
      end
    end
  end

  task automatic run_op(input logic [2*NB-1:0] tv, input logic [NB-1:0] nv, input logic [63:0] n0v,
                        input logic [NB-1:0] expv, input bit glitch);
    bit got;
    bit busy_bad;
    t = tv; n = nv; n0prime = n0v; start = 1'b1;
    exp_q.push_back(expv);
    st_q.push_back(cyc);
    got = 1'b0;
    busy_bad = 1'b0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      start = glitch && (k == 3 || k == 10);
      t = {rand512(), rand512()};
      n = rand512();
      n0prime = {$urandom, $urandom};
      if (done) got = 1'b1;
      else if (!busy) busy_bad = 1'b1;
    end
    check("done_seen", {{(NB-1){1'b0}}, got}, {{(NB-1){1'b0}}, 1'b1});
    check("busy_window", {{(NB-1){1'b0}}, busy_bad}, {NB{1'b0}});
    if (!got) begin
      exp_q.delete();
      st_q.delete();
    end
    start = 1'b0;
    @(negedge clk);
    check("single_pulse", {{(NB-1){1'b0}}, done}, {NB{1'b0}});
  endtask

  task automatic do_run(input string name, input logic [2*NB-1:0] tv, input logic [NB-1:0] nv,
                        input logic [63:0] n0v, input logic [NB-1:0] lit, input bit glitch);
    check({"model_", name}, model(tv, nv), lit);
    run_op(tv, nv, n0v, lit, glitch);
  endtask

  initial begin
    logic [NB-1:0]   nall;
    logic [NB-1:0]   n3;
    logic [2*NB-1:0] tv;
    logic [63:0]     n0_3;
    bit              saw;

    nall = '1;
    n3   = NB'(3);
    n0_3 = 64'h5555555555555555;
    rst_n = 1'b0; start = 1'b0; t = '0; n = '0; n0prime = '0;
    repeat (3) @(negedge clk);
    check("rst_result", result, {NB{1'b0}});
    check("rst_busy", {{(NB-1){1'b0}}, busy}, {NB{1'b0}});
    check("rst_done", {{(NB-1){1'b0}}, done}, {NB{1'b0}});
    check("n0_of_3", {448'd0, calc_n0(64'd3)}, {448'd0, n0_3});
    rst_n = 1'b1;
    @(negedge clk);

    do_run("t5", (2*NB)'(5), nall, 64'd1, NB'(5), 1'b0);
    tv = '0; tv[NB] = 1'b1;
    do_run("t2R", tv, nall, 64'd1, NB'(1), 1'b0);
    do_run("t_eq_n", {{NB{1'b0}}, nall}, nall, 64'd1, NB'(0), 1'b0);
    do_run("n3_t10", (2*NB)'(10), n3, n0_3, NB'(1), 1'b0);
    do_run("n3_t9", (2*NB)'(9), n3, n0_3, NB'(0), 1'b0);
    do_run("glitch", (2*NB)'(11), n3, n0_3, NB'(2), 1'b1);

    // reset in the middle of a run
    t = (2*NB)'(7); n = nall; n0prime = 64'd1; start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_result", result, {NB{1'b0}});
    check("midrst_busy", {{(NB-1){1'b0}}, busy}, {NB{1'b0}});
    check("midrst_done", {{(NB-1){1'b0}}, done}, {NB{1'b0}});
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done) saw = 1'b1;
    end
    check("midrst_no_done", {{(NB-1){1'b0}}, saw}, {NB{1'b0}});
    do_run("after_reset", (2*NB)'(10), n3, n0_3, NB'(1), 1'b0);

    for (int r = 0; r < 1000; r++) begin
      logic [NB-1:0] nv;
      logic [NB-1:0] hi;
      nv = rand512();
      nv[0] = 1'b1;
      if (nv == NB'(1)) nv = NB'(3);
      hi = rand512() % nv;
      tv = {hi, rand512()};
      run_op(tv, nv, calc_n0(nv[63:0]), model(tv, nv), 1'b0);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
